// File: rtl/flex_counter_pkg.sv
// Shared types and encodings for the multi-channel flexible counter.
// Imported by the per-channel counter and the top level.
package flex_counter_pkg;

    typedef enum logic {
        CH_RUN,
        CH_DONE
    } ch_state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/flex_counter_multi_if.sv
// Control/status bundle for a bank of flexible counters.
// Channel i occupies bit i, or slice [i*NUM_CNT_BITS +: NUM_CNT_BITS].
interface flex_counter_multi_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 4
);

    logic [NUM_CH-1:0]              clear;
    logic [NUM_CH-1:0]              load;
    logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
    logic [NUM_CH-1:0]              count_enable;
    logic [NUM_CH-1:0]              count_down;
    logic [NUM_CH-1:0]              oneshot;
    logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
    logic [NUM_CH-1:0]              rollover_flag;
    logic [NUM_CH-1:0]              rollover_strobe;
    logic [NUM_CH-1:0]              done;

    modport master (
        output clear, load, load_val, count_enable,
        output count_down, oneshot, rollover_val,
        input  count_out, rollover_flag, rollover_strobe, done
    );

    modport slave (
        input  clear, load, load_val, count_enable,
        input  count_down, oneshot, rollover_val,
        output count_out, rollover_flag, rollover_strobe, done
    );

endinterface

// File: rtl/flex_counter_ch.sv
// One flexible counter channel: up/down, wrap/one-shot, clear and load.
// All outputs registered; terminal is rollover_val (up) or 1 (down).
module flex_counter_ch
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    oneshot,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    rollover_strobe,
    output logic                    done
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    ch_state_t               state;
    logic [NUM_CNT_BITS-1:0] term;
    logic [NUM_CNT_BITS-1:0] step_val;
    logic                    rv_zero;
    logic                    step;
    logic                    hit;

    always_comb begin
        term     = (count_down == DIR_DOWN) ? ONE : rollover_val;
        rv_zero  = (rollover_val == '0);
        step     = count_enable && (state == CH_RUN) && !rv_zero;
        step_val = count_out;
        // Out-of-range counts re-enter the 1..rollover_val sequence
        if (count_down == DIR_UP) begin
            if (count_out >= rollover_val) step_val = ONE;
            else                           step_val = count_out + ONE;
        end else begin
            if (count_out <= ONE || count_out > rollover_val)
                step_val = rollover_val;
            else
                step_val = count_out - ONE;
        end
        hit = (step_val == term);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= CH_RUN;
            count_out       <= '0;
            rollover_flag   <= 1'b0;
            rollover_strobe <= 1'b0;
            done            <= 1'b0;
        end else if (clear) begin
            state           <= CH_RUN;
            count_out       <= '0;
            rollover_flag   <= 1'b0;
            rollover_strobe <= 1'b0;
            done            <= 1'b0;
        end else if (load) begin
            state           <= CH_RUN;
            count_out       <= load_val;
            rollover_flag   <= (load_val == term);
            rollover_strobe <= 1'b0;
            done            <= 1'b0;
        end else if (step) begin
            count_out       <= step_val;
            rollover_flag   <= hit;
            rollover_strobe <= hit;
            if (hit && oneshot == MODE_ONESHOT) begin
                state <= CH_DONE;
                done  <= 1'b1;
            end
        end else begin
            rollover_strobe <= 1'b0;
            // A halted channel keeps its flag regardless of setting changes
            if (state == CH_RUN)
                rollover_flag <= !rv_zero && (count_out == term);
        end
    end

endmodule

// File: rtl/flex_counter_multi.sv
// Bank of NUM_CH independent flexible counters behind one interface.
// Pure packing/unpacking; each channel is a flex_counter_ch.
module flex_counter_multi
    import flex_counter_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_CH       = 4
) (
    input logic                clk,
    input logic                n_rst,
    flex_counter_multi_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        flex_counter_ch #(
            .NUM_CNT_BITS(NUM_CNT_BITS)
        ) u_ch (
            .clk            (clk),
            .n_rst          (n_rst),
            .clear          (bus.clear[i]),
            .load           (bus.load[i]),
            .load_val       (bus.load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_enable   (bus.count_enable[i]),
            .count_down     (bus.count_down[i]),
            .oneshot        (bus.oneshot[i]),
            .rollover_val   (bus.rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .count_out      (bus.count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
            .rollover_flag  (bus.rollover_flag[i]),
            .rollover_strobe(bus.rollover_strobe[i]),
            .done           (bus.done[i])
        );
    end

endmodule

// File: tb/tb_flex_counter_multi.sv
// Directed bench for flex_counter_multi: vector table plus corner sequences.
// Expected values are hand-derived from the counter behaviour.
module tb_flex_counter_multi;

    localparam int W  = 4;
    localparam int CH = 4;

    typedef struct {
        int         ch;
        logic       clr;
        logic       ld;
        logic       en;
        logic       dn;
        logic       os;
        logic [3:0] lval;
        logic [3:0] rval;
        logic [3:0] cnt;
        logic       flg;
        logic       stb;
        logic       dne;
    } vec_t;

    logic clk;
    logic n_rst;
    int   errors;
    int   checks;

    logic       clr_a [CH];
    logic       ld_a  [CH];
    logic       en_a  [CH];
    logic       dn_a  [CH];
    logic       os_a  [CH];
    logic [3:0] lv_a  [CH];
    logic [3:0] rv_a  [CH];

    vec_t vecs[$];

    flex_counter_multi_if #(.NUM_CNT_BITS(W), .NUM_CH(CH)) bus ();

    flex_counter_multi #(.NUM_CNT_BITS(W), .NUM_CH(CH)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < CH; i++) begin
            bus.clear[i]                 = clr_a[i];
            bus.load[i]                  = ld_a[i];
            bus.count_enable[i]          = en_a[i];
            bus.count_down[i]            = dn_a[i];
            bus.oneshot[i]               = os_a[i];
            bus.load_val[i*W +: W]       = lv_a[i];
            bus.rollover_val[i*W +: W]   = rv_a[i];
        end
    endtask

    task automatic quiet();
        for (int i = 0; i < CH; i++) begin
            clr_a[i] = 1'b0;
            ld_a[i]  = 1'b0;
            en_a[i]  = 1'b0;
        end
    endtask

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(int ch, logic clr, logic ld, logic en,
                                logic dn, logic os, logic [3:0] lval,
                                logic [3:0] rval, logic [3:0] cnt,
                                logic flg, logic stb, logic dne);
        vec_t v;
        v.ch = ch;   v.clr = clr;   v.ld = ld;     v.en = en;
        v.dn = dn;   v.os = os;     v.lval = lval; v.rval = rval;
        v.cnt = cnt; v.flg = flg;   v.stb = stb;   v.dne = dne;
        return v;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < CH; i++) begin
            dn_a[i] = 1'b0;
            os_a[i] = 1'b0;
            lv_a[i] = '0;
            rv_a[i] = '0;
        end
        quiet();
        drive();
        n_rst = 1'b0;

        // Up-wrap on ch0, rollover 5
        for (int k = 0; k < 12; k++) begin
            logic [3:0] c;
            c = 4'((k % 5) + 1);
            vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5, c, c == 5, c == 5, 0));
        end
        // Down-wrap on ch1, rollover 3, from clear
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 3, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 3, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 3, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 3, 3, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 3, 2, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 3, 1, 1, 1, 0));
        // One-shot on ch2, rollover 4, then reload
        vecs.push_back(mk(2, 1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 1, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 2, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 3, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 4, 1, 1, 1));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 4, 1, 0, 1));
        vecs.push_back(mk(2, 0, 0, 1, 0, 0, 0, 4, 4, 1, 0, 1));
        vecs.push_back(mk(2, 0, 1, 1, 0, 1, 2, 4, 2, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 3, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 4, 1, 1, 1));
        vecs.push_back(mk(2, 0, 0, 1, 0, 1, 0, 4, 4, 1, 0, 1));
        // Range and boundary on ch0
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 9, 5, 9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 6, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 9, 6, 9, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 6, 6, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 6, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", bus.count_out, 16'h0000);
        check("rst_flag", 16'(bus.rollover_flag), 16'h0);
        check("rst_strobe", 16'(bus.rollover_strobe), 16'h0);
        check("rst_done", 16'(bus.done), 16'h0);
        @(negedge clk);
        n_rst = 1'b1;

        foreach (vecs[n]) begin
            vec_t v;
            v = vecs[n];
            quiet();
            clr_a[v.ch] = v.clr;
            ld_a[v.ch]  = v.ld;
            en_a[v.ch]  = v.en;
            dn_a[v.ch]  = v.dn;
            os_a[v.ch]  = v.os;
            lv_a[v.ch]  = v.lval;
            rv_a[v.ch]  = v.rval;
            drive();
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", n),
                  16'(bus.count_out[v.ch*W +: W]), 16'(v.cnt));
            check($sformatf("v%0d_flag", n),
                  16'(bus.rollover_flag[v.ch]), 16'(v.flg));
            check($sformatf("v%0d_strobe", n),
                  16'(bus.rollover_strobe[v.ch]), 16'(v.stb));
            check($sformatf("v%0d_done", n),
                  16'(bus.done[v.ch]), 16'(v.dne));
        end

        // Clear beats load on ch3 while ch0 steps alongside
        quiet();
        en_a[0] = 1'b1; dn_a[0] = 1'b0; rv_a[0] = 4'd5;
        clr_a[3] = 1'b1; ld_a[3] = 1'b1; lv_a[3] = 4'd7;
        dn_a[3] = 1'b0; rv_a[3] = 4'd9;
        drive();
        @(posedge clk);
        #1;
        check("prio_count", bus.count_out, 16'h0412);
        check("prio_strobe", 16'(bus.rollover_strobe), 16'h0);
        clr_a[3] = 1'b0;
        drive();
        @(posedge clk);
        #1;
        check("load_count", bus.count_out, 16'h7413);
        check("load_strobe", 16'(bus.rollover_strobe), 16'h0);
        check("load_flag3", 16'(bus.rollover_flag[3]), 16'h0);
        check("load_done", 16'(bus.done), 16'h4);

        // Asynchronous reset between edges with ch2 halted
        quiet();
        for (int i = 0; i < CH; i++) en_a[i] = 1'b1;
        drive();
        #1;
        n_rst = 1'b0;
        #1;
        check("arst_count", bus.count_out, 16'h0000);
        check("arst_flag", 16'(bus.rollover_flag), 16'h0);
        check("arst_done", 16'(bus.done), 16'h0);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("restart_count", bus.count_out, 16'h1131);
        check("restart_flag", 16'(bus.rollover_flag), 16'h0);
        check("restart_done", 16'(bus.done), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
